// File: rtl/fp16_pkg.sv
// fp16_pkg: shared definitions for the FP16 integer encoder.
//   - FP16 field widths, exponent bias and special encodings
//   - encoder FSM state enum
//   - helper that builds a signed infinity
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int FP_W  = 1 + EXP_W + MAN_W;
  localparam int BIAS  = 15;

  localparam logic [EXP_W-1:0] EXP_INF  = 5'h1F;
  // Exponent of a value whose leading one sits in bit 15 of the magnitude.
  localparam logic [EXP_W-1:0] EXP_TOP  = EXP_W'(BIAS + 15);
  localparam logic [FP_W-1:0]  POS_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } enc_state_e;

  function automatic logic [FP_W-1:0] fp16_inf(input logic sign);
    return {sign, EXP_INF, {MAN_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp16_round.sv
// fp16_round: combinational rounding and packing of a normalised FP16 value.
// Build option: ROUND_RNE_EN
//   defined   -> round-to-nearest-even with mantissa carry and infinity saturation
//   undefined -> truncation; guard and sticky are ignored
// Ports:
//   sign_i  sign bit
//   exp_i   biased exponent before rounding
//   man_i   10-bit mantissa (hidden bit dropped)
//   g_i     guard bit (first bit below the mantissa)
//   st_i    sticky bit (OR of all remaining bits)
//   fp_o    packed FP16 word
module fp16_round
  import fp16_pkg::*;
(
  input  logic             sign_i,
  input  logic [EXP_W-1:0] exp_i,
  input  logic [MAN_W-1:0] man_i,
  input  logic             g_i,
  input  logic             st_i,
  output logic [FP_W-1:0]  fp_o
);

`ifdef ROUND_RNE_EN
  logic             inc;
  logic [MAN_W:0]   man_sum;
  logic [EXP_W:0]   exp_sum;

  always_comb begin
    inc     = g_i & (st_i | man_i[0]);
    man_sum = {1'b0, man_i} + {{MAN_W{1'b0}}, inc};
    // A mantissa carry leaves man_sum[MAN_W-1:0] at zero, so only the exponent moves.
    exp_sum = {1'b0, exp_i} + {{EXP_W{1'b0}}, man_sum[MAN_W]};
    if (exp_sum >= {1'b0, EXP_INF}) begin
      fp_o = fp16_inf(sign_i);
    end else begin
      fp_o = {sign_i, exp_sum[EXP_W-1:0], man_sum[MAN_W-1:0]};
    end
  end
`else
  logic unused_rnd;
  assign unused_rnd = g_i ^ st_i;
  assign fp_o       = {sign_i, exp_i, man_i};
`endif

endmodule

// File: rtl/int_to_fp16_enc.sv
// int_to_fp16_enc: converts a 16-bit signed/unsigned integer into an FP16 word.
// Normalisation shifts one bit per cycle; rounding is done in fp16_round.
// Build option: ROUND_RNE_EN (round-to-nearest-even; otherwise truncation).
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   in_valid   request present
//   in_ready   encoder idle and able to accept
//   in_data    integer operand, sampled at the accept edge only
//   in_signed  1: in_data is two's complement, 0: unsigned
//   out_valid  out_data holds a finished result
//   out_ready  sink accepts the result
//   out_data   packed FP16 result
//
// state    | meaning
// ST_IDLE  | waiting for a request, in_ready high
// ST_NORM  | shifting magnitude left until bit 15 is set
// ST_ROUND | round, pack and register the result
// ST_DONE  | result presented until out_ready
module int_to_fp16_enc
  import fp16_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  input  logic            in_signed,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP_W-1:0] out_data
);

  enc_state_e      state_q, state_d;
  logic [15:0]     m_q, m_d;
  logic [3:0]      s_q, s_d;
  logic            sign_q, sign_d;
  logic [FP_W-1:0] out_q, out_d;

  logic            sign_in;
  logic [15:0]     mag_in;
  logic [EXP_W-1:0] exp_norm;
  logic [FP_W-1:0] rnd_fp;

  // Negating 0x8000 wraps back to 0x8000, which is the correct magnitude.
  assign sign_in  = in_signed & in_data[15];
  assign mag_in   = sign_in ? (~in_data + 16'd1) : in_data;
  assign exp_norm = EXP_TOP - {1'b0, s_q};

  fp16_round u_round (
    .sign_i (sign_q),
    .exp_i  (exp_norm),
    .man_i  (m_q[14:5]),
    .g_i    (m_q[4]),
    .st_i   (|m_q[3:0]),
    .fp_o   (rnd_fp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      s_q     <= '0;
      sign_q  <= 1'b0;
      out_q   <= POS_ZERO;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      sign_q  <= sign_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    s_d       = s_q;
    sign_d    = sign_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sign_d = sign_in;
          m_d    = mag_in;
          s_d    = '0;
          if (mag_in == 16'd0) begin
            // Zero is always packed as +0, regardless of operand sign.
            out_d   = POS_ZERO;
            state_d = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        if (m_q[15]) begin
          state_d = ST_ROUND;
        end else begin
          m_d = {m_q[14:0], 1'b0};
          s_d = s_q + 4'd1;
        end
      end
      ST_ROUND: begin
        out_d   = rnd_fp;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_data = out_q;

endmodule

// File: tb/tb_int_to_fp16_enc.sv
module tb_int_to_fp16_enc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  int_to_fp16_enc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Integer value of the operand as the source means it.
  function automatic int ref_val(input logic [15:0] d, input logic sg);
    if (sg) return int'($signed(d));
    return int'({16'h0000, d});
  endfunction

  // Position of the leading one of a positive integer.
  function automatic int ref_log2(input int mag);
    int e = 0;
    while ((1 << (e + 1)) <= mag) e++;
    return e;
  endfunction

  // FP16 value of an integer, from the real-number definition of the format.
  function automatic logic [15:0] ref_fp(input logic [15:0] d, input logic sg);
    int v, mag, e, q;
    logic neg;
    logic [4:0] ex;
    v   = ref_val(d, sg);
    neg = (v < 0);
    mag = neg ? -v : v;
    if (mag == 0) return 16'h0000;
    e = ref_log2(mag);
    if (e <= 10) q = mag << (10 - e);
    else         q = mag >> (e - 10);
`ifdef ROUND_RNE_EN
    if (e > 10) begin
      int rem, half;
      rem  = mag - (q << (e - 10));
      half = 1 << (e - 11);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 2048) begin
        q = 1024;
        e++;
      end
    end
`endif
    if (e + 15 >= 31) return {neg, 5'h1F, 10'h000};
    ex = 5'(e + 15);
    return {neg, ex, 10'(q)};
  endfunction

  // Clock edges after the accept edge until out_valid is visible.
  // Zero skips normalisation and is visible straight after the accept edge.
  function automatic int ref_lat(input logic [15:0] d, input logic sg);
    int v, mag;
    v   = ref_val(d, sg);
    mag = (v < 0) ? -v : v;
    if (mag == 0) return 0;
    return (15 - ref_log2(mag)) + 2;
  endfunction

  task automatic request(input logic [15:0] d, input logic sg);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = sg;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    // Operands are sampled at the accept edge only; scramble them afterwards.
    in_data   = 16'($urandom);
    in_signed = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_vdrop"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic conv(input logic [15:0] d, input logic sg, input logic [15:0] want,
                      input int want_lat, input string tag);
    int lat;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    request(d, sg);
    wait_valid(lat);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, want});
    chk({tag, "_lat"}, lat, want_lat);
    handshake(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] d, held;
    logic sg;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    conv(16'h0001, 1'b0, 16'h3C00, 17, "u1");
    conv(16'hFFFF, 1'b1, 16'hBC00, 17, "sm1");
    conv(16'h8000, 1'b1, 16'hF800, 2, "smin");
    conv(16'h8000, 1'b0, 16'h7800, 2, "u8000");
`ifdef ROUND_RNE_EN
    conv(16'd2051, 1'b0, 16'h6802, 6, "u2051");
    conv(16'd65535, 1'b0, 16'h7C00, 2, "umax");
`else
    conv(16'd2051, 1'b0, 16'h6801, 6, "u2051");
    conv(16'd65535, 1'b0, 16'h7BFF, 2, "umax");
`endif
    conv(16'd2049, 1'b0, 16'h6800, 6, "u2049");
    conv(16'h0000, 1'b1, 16'h0000, 0, "szero");

    // Sink stall: result must sit still and no new request may enter.
    request(16'd1000, 1'b0);
    wait_valid(lat);
    held = ref_fp(16'd1000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", {16'd0, out_data}, {16'd0, held});
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_rdy", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    handshake("stall");
    conv(16'hFF00, 1'b1, ref_fp(16'hFF00, 1'b1), ref_lat(16'hFF00, 1'b1), "b2b");

    // Reset while normalising 0x0001.
    request(16'h0001, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_rdy", {31'd0, in_ready}, 32'd1);
    chk("midrst_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    conv(16'h0004, 1'b0, 16'h4400, 15, "after_rst");

    for (int i = 0; i < 60; i++) begin
      d  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) d = d >> $urandom_range(0, 15);
      sg = 1'($urandom);
      conv(d, sg, ref_fp(d, sg), ref_lat(d, sg), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
